uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Upstream feeder for the UART byte transmitter: buffers bytes written by the CPU/bus side in a FIFO, then presents them one at a time on byte_to_transmit/begin_tx.
- Paces frames by counting baud_clk ticks, because the transmitter exposes no busy/done signal.
- Holds each byte stable for its whole 8N1 frame.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.
- FRAME_TICKS, 10, baud_clk ticks after acceptance until the transmitter is idle again (start + 8 data + stop).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- baud_clk  in  1  one-clk-wide baud strobe, same net as the transmitter's baud_clk.
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  enqueue strobe; one byte per cycle.
- full  out  1  FIFO full; writes are dropped.
- empty  out  1  FIFO empty.
- level  out  ADDR_W+1  current FIFO occupancy.
- busy  out  1  high when not empty or state != IDLE.
- byte_to_transmit  out  8  registered byte to transmitter.
- begin_tx  out  1  registered transmit request to transmitter.
- ovf  out  1  sticky overflow flag (see Optional Feature).
- ovf_clr  in  1  clears ovf.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: byte_to_transmit=0x00, begin_tx=0, ovf=0, level=0, empty=1, full=0, pointers=0, state=GUARD, tick counter=0.
- FIFO write: when wr_en && !full, store at wr_ptr; wr_ptr and level increment next cycle. When wr_en && full, drop the write and leave level unchanged, even if a pop occurs in the same cycle.
- full and empty decode from registered level.
- Simultaneous write and pop: level is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- States:
  - GUARD: entered from reset. Count FRAME_TICKS+1 baud_clk ticks, then go to IDLE. Covers a frame still in flight in the transmitter, which has no reset.
  - IDLE: if !empty, pop: byte_to_transmit <= mem[rd_ptr], rd_ptr++, level--, go to ARM on the next cycle with begin_tx <= 1.
  - ARM: begin_tx=1. On a cycle with baud_clk=1, the transmitter accepts: begin_tx <= 0, counter <= 0, go to SEND.
  - SEND: each baud_clk increments the counter. On the baud_clk where counter == FRAME_TICKS-1, go to IDLE and reset the counter.
- byte_to_transmit changes only in IDLE on a pop. It is stable from ARM through the last SEND tick.
- Latency: write into an empty queue in IDLE → pop on the next cycle → begin_tx high one cycle after that.
- Back-to-back frames: the next begin_tx rises 2 clk after SEND exits, so it is accepted on the next baud tick. Transmitter line gap = 0 extra bit times beyond its own idle tick.
- Reset asserted mid-frame: all state is cleared immediately and byte_to_transmit becomes 0x00. The in-flight frame's remaining data bits are corrupted (accepted). GUARD prevents a new request until that frame ends.
- baud_clk high in the same cycle as entry to ARM: not counted. ARM only samples baud_clk once begin_tx is registered high.

Optional Feature:
- Macro: UART_TX_QUEUE_OVF_EN.
- Defined: ovf sets to 1 on any cycle with wr_en && full and holds until ovf_clr=1. If set and clear occur in the same cycle, set wins.
- Undefined: ovf is tied 0, ovf_clr is ignored, no flag register is built.

Test Plan:
- Reset, then 11 baud ticks with the FIFO empty → state IDLE, begin_tx=0, busy=0, level=0.
- Write 0xA5 after the guard; baud tick every 16 clk → byte_to_transmit=0xA5, begin_tx high 2 clk after wr_en, drops the cycle after the first baud tick; busy falls after 10 further ticks.
- Write 0x01,0x02,0x03 back-to-back → level 1,2,3 then draining. Each byte is stable for exactly 11 baud ticks of transmitter activity, in order 0x01,0x02,0x03, with no overlap.
- Fill DEPTH=16 entries, then a 17th write of 0xFF → full=1, level=16, 0xFF never transmitted. With UART_TX_QUEUE_OVF_EN: ovf=1 until ovf_clr. Without it: ovf=0.
- Write and pop in the same cycle at level=5 → level stays 5; data order is preserved.
- Assert rst_n=0 during SEND tick 4, release, write 0x3C → begin_tx stays 0 until 11 baud ticks after release, then 0x3C is sent.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter that has no busy/done
// handshake. Each frame is paced by counting baud_clk ticks after the
// transmitter accepts begin_tx. byte_to_transmit is held for the whole frame.
// Optional build macro: UART_TX_QUEUE_OVF_EN adds the sticky overflow flag
// (ovf, cleared by ovf_clr). Without it, ovf is tied low.
module uart_tx_queue #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned FRAME_TICKS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_clk,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              busy,
    output logic [7:0]        byte_to_transmit,
    output logic              begin_tx,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int unsigned LEVEL_W = ADDR_W + 1;
    // The counter must reach FRAME_TICKS, because the guard uses FRAME_TICKS+1 ticks.
    localparam int unsigned CNT_W   = $clog2(FRAME_TICKS + 2);

    typedef enum logic [1:0] {
        GUARD,
        IDLE,
        ARM,
        SEND
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         byte_q, byte_d;
    logic               begin_tx_q, begin_tx_d;

    logic [7:0]         mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
    logic [LEVEL_W-1:0] level_q;
    logic               wr_ok;
    logic               pop;

    assign full  = (level_q == LEVEL_W'(DEPTH));
    assign empty = (level_q == '0);
    // A write is accepted only when the queue is not full at the start of the cycle.
    // A pop in the same cycle does not make room for it.
    assign wr_ok = wr_en && !full;
    assign pop   = (state_q == IDLE) && !empty;

    assign level            = level_q;
    assign busy             = !empty || (state_q != IDLE);
    assign byte_to_transmit = byte_q;
    assign begin_tx         = begin_tx_q;

    // FIFO storage. No reset is needed because data is only read behind level.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy. Pointers wrap naturally at DEPTH (a power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Sequencer registers: state, tick counter, and registered transmitter outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GUARD;
            cnt_q      <= '0;
            byte_q     <= '0;
            begin_tx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            begin_tx_q <= begin_tx_d;
        end
    end

    // Next-state logic: guard after reset, pop, wait for acceptance, then count out the frame.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        begin_tx_d = begin_tx_q;
        case (state_q)
            GUARD: begin
                if (baud_clk) begin
                    if (cnt_q == CNT_W'(FRAME_TICKS)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            IDLE: begin
                if (!empty) begin
                    byte_d     = mem[rd_ptr];
                    begin_tx_d = 1'b1;
                    state_d    = ARM;
                end
            end
            ARM: begin
                if (baud_clk) begin
                    begin_tx_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (baud_clk) begin
                    if (cnt_q == CNT_W'(FRAME_TICKS - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = GUARD;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef UART_TX_QUEUE_OVF_EN
    logic ovf_q;

    // Sticky overflow: a dropped write sets the flag, and a set wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (wr_en && full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed and randomized stimulus for uart_tx_queue.
// A behavioural model tracks queue contents and frame timing. A scoreboard
// checks each byte in order at the moment the transmitter accepts it.
`timescale 1ns/1ps
module tb_uart_tx_queue;

    localparam int DEPTH       = 16;
    localparam int ADDR_W      = 4;
    localparam int FRAME_TICKS = 10;
    localparam int GUARD_TICKS = FRAME_TICKS + 1;
`ifdef UART_TX_QUEUE_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            baud_clk = 1'b0;
    logic            wr_en    = 1'b0;
    logic            ovf_clr  = 1'b0;
    logic [7:0]      wr_data  = 8'h00;
    logic            full, empty, busy, begin_tx, ovf;
    logic [ADDR_W:0] level;
    logic [7:0]      byte_to_transmit;

    uart_tx_queue #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .FRAME_TICKS(FRAME_TICKS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .baud_clk(baud_clk),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .full(full),
        .empty(empty),
        .level(level),
        .busy(busy),
        .byte_to_transmit(byte_to_transmit),
        .begin_tx(begin_tx),
        .ovf(ovf),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_fifo[$];     // bytes waiting in the queue
    logic [7:0] exp_q[$];      // scoreboard: bytes expected at the transmitter, in order
    int         m_guard;       // guard ticks still to elapse after reset
    int         m_left;        // frame ticks still to elapse after acceptance
    bit         m_req;         // request outstanding at the transmitter
    logic [7:0] m_byte;
    bit         m_ovf;

    function automatic bit m_idle();
        return !m_req && (m_left == 0) && (m_guard == 0);
    endfunction

    task automatic m_reset();
        m_fifo.delete();
        exp_q.delete();
        m_guard = GUARD_TICKS;
        m_left  = 0;
        m_req   = 0;
        m_byte  = 8'h00;
        m_ovf   = 0;
    endtask

    task automatic m_step();
        bit do_wr, do_pop;
        do_wr  = wr_en && (m_fifo.size() < DEPTH);
        do_pop = m_idle() && (m_fifo.size() > 0);
        if (OVF_ON) begin
            if (wr_en && (m_fifo.size() == DEPTH)) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
        if (baud_clk) begin
            if (m_req) begin
                m_req  = 0;
                m_left = FRAME_TICKS;
            end else if (m_left > 0) begin
                m_left--;
            end else if (m_guard > 0) begin
                m_guard--;
            end
        end
        if (do_pop) begin
            m_byte = m_fifo.pop_front();
            m_req  = 1;
        end
        if (do_wr) begin
            m_fifo.push_back(wr_data);
            exp_q.push_back(wr_data);
        end
    endtask

    initial begin : model_proc
        m_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // Per-cycle comparison of the DUT state against the model
    initial begin : cycle_checker
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                check("begin_tx", begin_tx, m_req);
                check("byte_to_transmit", byte_to_transmit, m_byte);
                check("level", level, m_fifo.size());
                check("empty", empty, m_fifo.size() == 0);
                check("full", full, m_fifo.size() == DEPTH);
                check("busy", busy, (m_fifo.size() > 0) || !m_idle());
                check("ovf", ovf, m_ovf);
            end
        end
    end

    // Scoreboard monitor: a falling begin_tx marks acceptance of a byte
    logic       prev_bt = 1'b0;
    logic [7:0] sb_exp;
    initial begin : sb_monitor
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_bt = 1'b0;
            end else begin
                if (prev_bt && !begin_tx) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        sb_exp = exp_q.pop_front();
                        check("sb_byte", byte_to_transmit, sb_exp);
                    end
                end
                prev_bt = begin_tx;
            end
        end
    end

    // ---------------- driver ----------------
    int bdiv          = 16;
    int bcnt          = 0;
    int ticks_applied = 0;

    task automatic cyc(input logic we, input logic [7:0] d);
        @(negedge clk);
        if (baud_clk) ticks_applied++;
        baud_clk = (bcnt == bdiv - 1);
        bcnt     = (bcnt >= bdiv - 1) ? 0 : bcnt + 1;
        wr_en    = we;
        wr_data  = d;
        ovf_clr  = 1'b0;
    endtask

    task automatic wait_bt(input logic val, input string name);
        for (int i = 0; i < 2000 && begin_tx !== val; i++) cyc(1'b0, 8'h00);
        check(name, begin_tx, val);
    endtask

    task automatic wait_idle(input int bound, input string name);
        for (int i = 0; i < bound && busy !== 1'b0; i++) cyc(1'b0, 8'h00);
        check(name, busy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_byte", byte_to_transmit, 8'h00);
        check("rst_begin_tx", begin_tx, 1'b0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        rst_n = 1'b1;
    endtask

    int t0, ta;
    bit found;

    initial begin : driver
        cyc(1'b0, 8'h00);
        do_reset();

        // Guard: 11 ticks with an empty queue before the block reports idle
        t0 = ticks_applied;
        for (int i = 0; i < 1000 && (ticks_applied - t0) < GUARD_TICKS - 1; i++) cyc(1'b0, 8'h00);
        check("guard_busy_at_10", busy, 1'b1);
        for (int i = 0; i < 1000 && (ticks_applied - t0) < GUARD_TICKS; i++) cyc(1'b0, 8'h00);
        check("guard_idle_at_11", busy, 1'b0);
        cyc(1'b0, 8'h00);
        check("guard_begin_tx", begin_tx, 1'b0);
        check("guard_level", level, 0);

        // Single byte: begin_tx is seen 2 clk after wr_en, and the frame lasts 10 ticks after acceptance
        cyc(1'b1, 8'hA5);
        cyc(1'b0, 8'h00);
        check("lat_no_req_yet", begin_tx, 1'b0);
        cyc(1'b0, 8'h00);
        check("lat_req", begin_tx, 1'b1);
        check("lat_byte", byte_to_transmit, 8'hA5);
        wait_bt(1'b0, "a5_accept");
        ta = ticks_applied;
        wait_idle(2000, "a5_done");
        check("a5_frame_ticks", ticks_applied - ta, FRAME_TICKS);

        // Back-to-back bytes queued while a frame is in flight
        cyc(1'b1, 8'h10);
        wait_bt(1'b1, "b2b_req");
        wait_bt(1'b0, "b2b_accept");
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'h02);
        check("b2b_level1", level, 1);
        cyc(1'b1, 8'h03);
        check("b2b_level2", level, 2);
        cyc(1'b0, 8'h00);
        check("b2b_level3", level, 3);
        wait_idle(3000, "b2b_drain");

        // Fill during the guard, then overflow with 0xFF
        cyc(1'b0, 8'h00);
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom_range(0, 254)));
        cyc(1'b1, 8'hFF);
        cyc(1'b0, 8'h00);
        check("fill_full", full, 1'b1);
        check("fill_level", level, DEPTH);
        check("ovf_set", ovf, OVF_ON);
        cyc(1'b0, 8'h00);
        check("ovf_hold", ovf, OVF_ON);
        ovf_clr = 1'b1;
        cyc(1'b0, 8'h00);
        check("ovf_cleared", ovf, 1'b0);
        cyc(1'b1, 8'hEE);
        ovf_clr = 1'b1;
        cyc(1'b0, 8'h00);
        check("ovf_set_wins", ovf, OVF_ON);
        ovf_clr = 1'b1;
        cyc(1'b0, 8'h00);
        check("ovf_cleared2", ovf, 1'b0);

        // While draining, write in the same cycle as a pop at level 5
        found = 0;
        for (int i = 0; i < 6000; i++) begin
            cyc(1'b0, 8'h00);
            if (m_fifo.size() == 5 && m_idle()) begin
                found = 1;
                break;
            end
        end
        check("lvl5_found", found, 1'b1);
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        cyc(1'b0, 8'h00);
        check("lvl5_same_cycle", level, 5);
        wait_idle(6000, "fill_drain");

        // Reset during the 4th SEND tick; a new byte must wait for the guard
        cyc(1'b1, 8'hC3);
        wait_bt(1'b1, "mid_req");
        wait_bt(1'b0, "mid_accept");
        ta = ticks_applied;
        for (int i = 0; i < 1000 && (ticks_applied - ta) < 4; i++) cyc(1'b0, 8'h00);
        do_reset();
        t0 = ticks_applied;
        cyc(1'b1, 8'h3C);
        wait_bt(1'b1, "post_rst_req");
        check("post_rst_guard_ticks", ticks_applied - t0, GUARD_TICKS);
        check("post_rst_byte", byte_to_transmit, 8'h3C);
        wait_idle(2000, "post_rst_done");

        // Randomized traffic with varying baud rates
        for (int blk = 0; blk < 6; blk++) begin
            bdiv = $urandom_range(2, 16);
            bcnt = 0;
            for (int i = 0; i < 500; i++) begin
                cyc($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)));
                if ($urandom_range(0, 15) == 0) ovf_clr = 1'b1;
            end
        end
        wait_idle(20000, "rand_drain");
        cyc(1'b0, 8'h00);
        check("sb_leftover", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
